// File: rtl/mcop_sequencer_if.sv
// Handshake bundle between the issuing agent, the sequencer and the multi-cycle
// ready generator.
interface mcop_sequencer_if #(
   parameter int WID  = 6,
   parameter int CNTW = 16
);
   logic            req_vld_i;
   logic            req_rdy_o;
   logic [WID-1:0]  req_id_i;
   logic            abort_i;
   logic            op_go_o;
   logic [WID-1:0]  op_id_o;
   logic            op_rdy_i;
   logic [WID-1:0]  op_id_i;
   logic            rsp_vld_o;
   logic            rsp_rdy_i;
   logic [WID-1:0]  rsp_id_o;
   logic            rsp_err_o;
   logic            mism_o;
   logic [CNTW-1:0] done_cnt_o;

   modport slave (
      input  req_vld_i, req_id_i, abort_i, op_rdy_i, op_id_i, rsp_rdy_i,
      output req_rdy_o, op_go_o, op_id_o, rsp_vld_o, rsp_id_o, rsp_err_o,
             mism_o, done_cnt_o
   );

   modport master (
      output req_vld_i, req_id_i, abort_i, op_rdy_i, op_id_i, rsp_rdy_i,
      input  req_rdy_o, op_go_o, op_id_o, rsp_vld_o, rsp_id_o, rsp_err_o,
             mism_o, done_cnt_o
   );
endinterface

// File: rtl/mcop_sequencer.sv
// Issue/completion controller: issues one tagged op to the ready generator,
// waits for its tagged completion, and returns a tagged response.
module mcop_sequencer #(
   parameter int WID  = 6,
   parameter int TMO  = 64,
   parameter int CNTW = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   mcop_sequencer_if.slave bus
);

   localparam int TW = $clog2(TMO);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_opGo,    w_opGo;
   logic [WID-1:0]  r_opId,    w_opId;
   logic            r_rspVld,  w_rspVld;
   logic [WID-1:0]  r_rspId,   w_rspId;
   logic            r_rspErr,  w_rspErr;
   logic            r_mism,    w_mism;
   logic [CNTW-1:0] r_doneCnt, w_doneCnt;
   logic [TW-1:0]   r_timer,   w_timer;

   logic            w_match;
   logic            w_timeout;

   assign w_match   = bus.op_rdy_i && (bus.op_id_i == r_opId);
   assign w_timeout = (r_timer == TW'(TMO - 1));

   // Every output except req_rdy_o is computed here and registered below.
   always_comb begin
      w_nextState = r_state;
      w_opGo      = r_opGo;
      w_opId      = r_opId;
      w_rspVld    = r_rspVld;
      w_rspId     = r_rspId;
      w_rspErr    = r_rspErr;
      w_mism      = 1'b0;
      w_doneCnt   = r_doneCnt;
      w_timer     = r_timer;

      case (r_state)
         IDLE: begin
            if (bus.req_vld_i) begin
               w_opId      = bus.req_id_i;
               w_opGo      = 1'b1;
               w_timer     = '0;
               w_nextState = RUN;
            end
         end

         RUN: begin
            w_timer = r_timer + TW'(1);
            w_mism  = bus.op_rdy_i && !w_match;
            // Abort outranks a completion, which in turn outranks the timeout.
            if (bus.abort_i || w_match || w_timeout) begin
               w_opGo      = 1'b0;
               w_rspErr    = bus.abort_i || !w_match;
               w_rspId     = r_opId;
               w_rspVld    = 1'b1;
               w_nextState = RESP;
            end
         end

         RESP: begin
            if (r_rspVld && bus.rsp_rdy_i) begin
               w_rspVld = 1'b0;
               if (!r_rspErr) begin
                  w_doneCnt = r_doneCnt + CNTW'(1);
               end
               w_nextState = IDLE;
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_opGo    <= 1'b0;
         r_opId    <= '0;
         r_rspVld  <= 1'b0;
         r_rspId   <= '0;
         r_rspErr  <= 1'b0;
         r_mism    <= 1'b0;
         r_doneCnt <= '0;
         r_timer   <= '0;
      end else begin
         r_state   <= w_nextState;
         r_opGo    <= w_opGo;
         r_opId    <= w_opId;
         r_rspVld  <= w_rspVld;
         r_rspId   <= w_rspId;
         r_rspErr  <= w_rspErr;
         r_mism    <= w_mism;
         r_doneCnt <= w_doneCnt;
         r_timer   <= w_timer;
      end
   end

   assign bus.req_rdy_o  = (r_state == IDLE);
   assign bus.op_go_o    = r_opGo;
   assign bus.op_id_o    = r_opId;
   assign bus.rsp_vld_o  = r_rspVld;
   assign bus.rsp_id_o   = r_rspId;
   assign bus.rsp_err_o  = r_rspErr;
   assign bus.mism_o     = r_mism;
   assign bus.done_cnt_o = r_doneCnt;

endmodule

// File: tb/tb_mcop_sequencer.sv
// Bench for mcop_sequencer: the bench plays both requester and ready generator
// and predicts each transaction's outcome from its chosen event cycles.
module tb_mcop_sequencer;

   localparam int WID  = 6;
   localparam int TMO  = 64;
   localparam int CNTW = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mcop_sequencer_if #(.WID(WID), .CNTW(CNTW)) bus ();

   mcop_sequencer #(.WID(WID), .TMO(TMO), .CNTW(CNTW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   logic [CNTW-1:0] expCnt = '0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic reqVld, input logic [WID-1:0] reqId,
                                input logic abort, input logic opRdy,
                                input logic [WID-1:0] opId, input logic rspRdy);
      bus.req_vld_i = reqVld;
      bus.req_id_i  = reqId;
      bus.abort_i   = abort;
      bus.op_rdy_i  = opRdy;
      bus.op_id_i   = opId;
      bus.rsp_rdy_i = rspRdy;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_rdy"},  32'(bus.req_rdy_o),  32'd1);
      checkOutput({tag, "_op_go"},    32'(bus.op_go_o),    32'd0);
      checkOutput({tag, "_op_id"},    32'(bus.op_id_o),    32'd0);
      checkOutput({tag, "_rsp_vld"},  32'(bus.rsp_vld_o),  32'd0);
      checkOutput({tag, "_rsp_id"},   32'(bus.rsp_id_o),   32'd0);
      checkOutput({tag, "_rsp_err"},  32'(bus.rsp_err_o),  32'd0);
      checkOutput({tag, "_mism"},     32'(bus.mism_o),     32'd0);
      checkOutput({tag, "_done_cnt"}, 32'(bus.done_cnt_o), 32'd0);
   endtask

   // One full transaction. Event positions j count RUN cycles from 1 (the
   // first clock edge after accept); 0 means the event never happens.
   task automatic runTxn(input logic [WID-1:0] id, input int abortAt, input int matchAt,
                         input int mismAt, input logic [WID-1:0] mismId, input int rspWait);
      int endJ;
      logic expErr;
      logic [WID-1:0] junk;
      junk = id ^ {WID{1'b1}};

      endJ = TMO;
      if (matchAt > 0 && matchAt < endJ) endJ = matchAt;
      if (abortAt > 0 && abortAt <= endJ) endJ = abortAt;
      expErr = !((matchAt == endJ) && (abortAt != endJ));
      if (mismAt >= endJ) mismAt = 0;

      @(negedge clk);
      checkOutput("idle_req_rdy", 32'(bus.req_rdy_o), 32'd1);
      checkOutput("idle_op_go",   32'(bus.op_go_o),   32'd0);
      applyStimulus(1'b1, id, 1'b0, 1'b0, '0, 1'b0);

      @(negedge clk);
      checkOutput("acc_op_go",   32'(bus.op_go_o),   32'd1);
      checkOutput("acc_op_id",   32'(bus.op_id_o),   32'(id));
      checkOutput("acc_req_rdy", 32'(bus.req_rdy_o), 32'd0);

      for (int j = 1; j <= endJ; j++) begin
         applyStimulus(1'b1, junk, 1'(j == abortAt), 1'((j == matchAt) || (j == mismAt)),
                       (j == matchAt) ? id : mismId, 1'b0);
         @(negedge clk);
         if (j < endJ) begin
            checkOutput("run_op_go",   32'(bus.op_go_o),   32'd1);
            checkOutput("run_op_id",   32'(bus.op_id_o),   32'(id));
            checkOutput("run_rsp_vld", 32'(bus.rsp_vld_o), 32'd0);
            checkOutput("run_mism",    32'(bus.mism_o),    32'(j == mismAt));
         end
      end

      checkOutput("end_rsp_vld", 32'(bus.rsp_vld_o), 32'd1);
      checkOutput("end_rsp_id",  32'(bus.rsp_id_o),  32'(id));
      checkOutput("end_rsp_err", 32'(bus.rsp_err_o), 32'(expErr));
      checkOutput("end_op_go",   32'(bus.op_go_o),   32'd0);
      checkOutput("end_req_rdy", 32'(bus.req_rdy_o), 32'd0);
      checkOutput("end_mism",    32'(bus.mism_o),    32'd0);

      // Late completions and aborts while the response waits must change nothing.
      for (int w = 0; w < rspWait; w++) begin
         applyStimulus(1'b1, junk, 1'($urandom_range(0, 1)), 1'b1, id, 1'b0);
         @(negedge clk);
         checkOutput("hold_rsp_vld", 32'(bus.rsp_vld_o), 32'd1);
         checkOutput("hold_rsp_id",  32'(bus.rsp_id_o),  32'(id));
         checkOutput("hold_rsp_err", 32'(bus.rsp_err_o), 32'(expErr));
         checkOutput("hold_op_go",   32'(bus.op_go_o),   32'd0);
         checkOutput("hold_req_rdy", 32'(bus.req_rdy_o), 32'd0);
         checkOutput("hold_mism",    32'(bus.mism_o),    32'd0);
      end

      applyStimulus(1'b1, junk, 1'b0, 1'b0, '0, 1'b1);
      if (!expErr) expCnt = expCnt + 1'b1;
      @(negedge clk);
      checkOutput("ack_rsp_vld",  32'(bus.rsp_vld_o),  32'd0);
      checkOutput("ack_req_rdy",  32'(bus.req_rdy_o),  32'd1);
      checkOutput("ack_op_go",    32'(bus.op_go_o),    32'd0);
      checkOutput("ack_done_cnt", 32'(bus.done_cnt_o), 32'(expCnt));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      $display("[TB] directed transactions");
      runTxn(6'h15, 0, 5, 0, 6'h00, 0);
      runTxn(6'h2A, 0, 0, 0, 6'h00, 1);
      runTxn(6'h0C, 2, 0, 0, 6'h00, 3);
      runTxn(6'h15, 0, 9, 4, 6'h02, 0);
      runTxn(6'h33, 0, 7, 0, 6'h00, 10);
      runTxn(6'h01, 0, TMO, 10, 6'h11, 0);
      runTxn(6'h3F, 6, 6, 3, 6'h00, 1);
      runTxn(6'h00, 0, 1, 0, 6'h00, 0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 20; t++) begin
         logic [WID-1:0] id;
         int abortAt, matchAt, mismAt;
         id      = WID'($urandom);
         abortAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TMO) : 0;
         matchAt = ($urandom_range(0, 3) != 0) ? $urandom_range(1, TMO) : 0;
         mismAt  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, TMO) : 0;
         runTxn(id, abortAt, matchAt, mismAt, id ^ WID'($urandom_range(1, 63)),
                $urandom_range(0, 4));
      end

      $display("[TB] completion counter wrap");
      @(negedge clk);
      force dut.r_doneCnt = {CNTW{1'b1}};
      #1;
      release dut.r_doneCnt;
      expCnt = {CNTW{1'b1}};
      checkOutput("preload_done_cnt", 32'(bus.done_cnt_o), 32'(expCnt));
      runTxn(6'h2B, 0, 3, 0, 6'h00, 0);
      runTxn(6'h2C, 0, 4, 0, 6'h00, 0);

      $display("[TB] asynchronous reset in RUN");
      @(negedge clk);
      applyStimulus(1'b1, 6'h19, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("prerst_op_go", 32'(bus.op_go_o), 32'd1);
      #2 rst = 1'b1;
      #1 checkResetOutputs("rst_run");
      @(negedge clk);
      rst = 1'b0;
      expCnt = '0;

      $display("[TB] asynchronous reset in RESP");
      runTxn(6'h05, 0, 2, 0, 6'h00, 0);
      @(negedge clk);
      applyStimulus(1'b1, 6'h26, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'h26, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("prerst_rsp_vld", 32'(bus.rsp_vld_o), 32'd1);
      #2 rst = 1'b1;
      #1 checkResetOutputs("rst_resp");
      @(negedge clk);
      rst = 1'b0;
      expCnt = '0;
      runTxn(6'h0F, 0, 3, 0, 6'h00, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
